// File: rtl/conv_encoder_r12.sv
// Rate-1/2 feed-forward convolutional encoder.
// Encodes FRAME_LEN info bits per frame, optionally followed by K-1 zero
// tail bits that drive the trellis back to state 0. One coded word is
// produced for every accepted or tail bit, one cycle later.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start; o_rdy low
// DATA  | accepting info bits; o_rdy high
// TAIL  | flushing K-1 zero bits; o_rdy low

module conv_encoder_r12 #(
    parameter int          K         = 7,
    parameter logic [31:0] G0        = 32'o171,
    parameter logic [31:0] G1        = 32'o133,
    parameter int          FRAME_LEN = 1024,
    parameter bit          TAIL_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_vld,
    input  logic       i_bit,
    output logic       o_rdy,
    output logic       o_vld,
    output logic [1:0] o_word,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_busy
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(K);
    localparam logic [K-1:0] TAP0 = G0[K-1:0];
    localparam logic [K-1:0] TAP1 = G1[K-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [K-2:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic [1:0]    word_q, word_d;
    logic          sof_q, sof_d;
    logic          eof_q, eof_d;
    logic          busy_q, busy_d;

    logic          enc_en;
    logic          enc_bit;
    logic [K-1:0]  win;

    // Next-state, counters and the coded word for the bit encoded this cycle.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        vld_d   = 1'b0;
        word_d  = word_q;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        enc_en  = 1'b0;
        enc_bit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (i_vld) begin
                    enc_en  = 1'b1;
                    enc_bit = i_bit;
                    cnt_d   = cnt_q + 1'b1;
                    sof_d   = (cnt_q == '0);
                    if (cnt_q == CW'(FRAME_LEN - 1)) begin
                        tcnt_d = '0;
                        if (TAIL_EN) begin
                            state_d = S_TAIL;
                        end else begin
                            state_d = S_IDLE;
                            eof_d   = 1'b1;
                        end
                    end
                end
            end
            S_TAIL: begin
                enc_en  = 1'b1;
                enc_bit = 1'b0;
                tcnt_d  = tcnt_q + 1'b1;
                if (tcnt_q == TW'(K - 2)) begin
                    state_d = S_IDLE;
                    eof_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Window: current bit in the MSB, oldest history bit in bit 0.
        win = {enc_bit, sr_q};
        if (enc_en) begin
            vld_d  = 1'b1;
            word_d = {^(win & TAP1), ^(win & TAP0)};
            sr_d   = win[K-1:1];
        end

        rdy_d  = (state_d == S_DATA);
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            word_q  <= 2'b00;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            word_q  <= word_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
        end
    end

    assign o_rdy  = rdy_q;
    assign o_vld  = vld_q;
    assign o_word = word_q;
    assign o_sof  = sof_q;
    assign o_eof  = eof_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_conv_encoder_r12.sv
// Directed bench for conv_encoder_r12: small K=3 frames with hand-computed
// words (with and without tail), reset mid-frame, ignored start/valid
// pulses, back-to-back frames, and one long default-parameter frame
// checked against a tap-by-tap reference model.

module tb_conv_encoder_r12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;
    logic vld = 1'b0, bit_i = 1'b0, c_vld = 1'b0, c_bit = 1'b0;

    logic a_rdy, a_vld, a_sof, a_eof, a_busy;
    logic b_rdy, b_vld, b_sof, b_eof, b_busy;
    logic c_rdy, c_vld_o, c_sof, c_eof, c_busy;
    logic [1:0] a_word, b_word, c_word;

    conv_encoder_r12 #(.K(3), .G0(32'b111), .G1(32'b101), .FRAME_LEN(4), .TAIL_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .i_start(a_start), .i_vld(vld), .i_bit(bit_i),
        .o_rdy(a_rdy), .o_vld(a_vld), .o_word(a_word), .o_sof(a_sof), .o_eof(a_eof), .o_busy(a_busy));

    conv_encoder_r12 #(.K(3), .G0(32'b111), .G1(32'b101), .FRAME_LEN(4), .TAIL_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .i_start(b_start), .i_vld(vld), .i_bit(bit_i),
        .o_rdy(b_rdy), .o_vld(b_vld), .o_word(b_word), .o_sof(b_sof), .o_eof(b_eof), .o_busy(b_busy));

    conv_encoder_r12 dut_c (
        .clk(clk), .reset(reset), .i_start(c_start), .i_vld(c_vld), .i_bit(c_bit),
        .o_rdy(c_rdy), .o_vld(c_vld_o), .o_word(c_word), .o_sof(c_sof), .o_eof(c_eof), .o_busy(c_busy));

    int total = 0;
    int bad   = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] qc[$];
    logic       hist[$];

    logic [1:0] c1_words [0:5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    logic [3:0] pat = 4'b1101;
    logic [6:0] cg0 = 7'o171;
    logic [6:0] cg1 = 7'o133;

    // Capture every emitted word as {eof, sof, word}.
    always @(negedge clk) begin
        if (a_vld)   qa.push_back({a_eof, a_sof, a_word});
        if (b_vld)   qb.push_back({b_eof, b_sof, b_word});
        if (c_vld_o) qc.push_back({c_eof, c_sof, c_word});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits();
        for (int i = 0; i < 4; i++) begin
            vld   = 1'b1;
            bit_i = pat[i];
            tick();
        end
        vld = 1'b0;
    endtask

    task automatic chk_frames(input string tag, input logic [3:0] q[$], input int nframes, input int nwords);
        logic [3:0] obs;
        logic [3:0] exp;
        chk({tag, "_count"}, q.size(), nframes * nwords);
        for (int f = 0; f < nframes; f++) begin
            for (int i = 0; i < nwords; i++) begin
                obs = (f * nwords + i < q.size()) ? q[f * nwords + i] : 4'hF;
                exp = {(i == nwords - 1), (i == 0), c1_words[i]};
                chk($sformatf("%s_f%0d_w%0d", tag, f, i), obs, exp);
            end
        end
    endtask

    function automatic logic [1:0] ref_word(input int n);
        logic p0, p1, b;
        p0 = 1'b0;
        p1 = 1'b0;
        for (int t = 0; t < 7; t++) begin
            b  = (n - t >= 0) ? hist[n - t] : 1'b0;
            p0 = p0 ^ (b & cg0[6 - t]);
            p1 = p1 ^ (b & cg1[6 - t]);
        end
        return {p1, p0};
    endfunction

    initial begin
        int n, guard, rdy_bad, word_bad, first_bad, w;
        logic [3:0] obs, exp;

        // Reset state
        tick();
        tick();
        chk("rst_a", {a_rdy, a_vld, a_word, a_sof, a_eof, a_busy}, 0);
        chk("rst_b", {b_rdy, b_vld, b_word, b_sof, b_eof, b_busy}, 0);
        chk("rst_c", {c_rdy, c_vld_o, c_word, c_sof, c_eof, c_busy}, 0);
        reset = 1'b0;
        tick();

        // K=3 frame with tail (a) and without tail (b)
        qa.delete();
        qb.delete();
        a_start = 1'b1;
        b_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
        chk("a_data_rdy", {a_busy, a_rdy}, 2'b11);
        chk("b_data_rdy", {b_busy, b_rdy}, 2'b11);
        send_bits();
        chk("a_tail_rdy", {a_busy, a_rdy}, 2'b10);
        chk("b_done_idle", {b_busy, b_rdy}, 2'b00);
        repeat (6) tick();
        chk("a_done_idle", {a_busy, a_rdy}, 2'b00);
        chk_frames("case1", qa, 1, 6);
        chk_frames("case2", qb, 1, 4);

        // Start pulses in DATA/TAIL, valid in TAIL, restart right after eof
        qa.delete();
        a_start = 1'b1;
        tick();
        vld = 1'b1; bit_i = 1'b1; a_start = 1'b1;
        tick();
        a_start = 1'b0; bit_i = 1'b0;
        tick();
        bit_i = 1'b1;
        tick();
        tick();
        a_start = 1'b1; vld = 1'b1; bit_i = 1'b1;
        tick();
        chk("tail_ign", {a_busy, a_rdy}, 2'b10);
        tick();
        chk("eof_idle", {a_eof, a_vld, a_busy}, 3'b110);
        a_start = 1'b1; vld = 1'b0;
        tick();
        a_start = 1'b0;
        chk("restart", {a_busy, a_rdy}, 2'b11);
        send_bits();
        repeat (4) tick();
        vld = 1'b1; bit_i = 1'b1;
        repeat (3) tick();
        vld = 1'b0;
        chk("idle_vld", {a_busy, a_rdy, a_vld}, 3'b000);
        tick();
        chk_frames("case56", qa, 2, 6);

        // Reset during the second info bit, then a clean frame
        a_start = 1'b1;
        tick();
        a_start = 1'b0; vld = 1'b1; bit_i = 1'b1;
        tick();
        bit_i = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; vld = 1'b0;
        chk("rst_mid", {a_rdy, a_vld, a_word, a_sof, a_eof, a_busy}, 0);
        qa.delete();
        tick();
        tick();
        chk("rst_quiet", qa.size(), 0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        send_bits();
        repeat (4) tick();
        chk_frames("case4", qa, 1, 6);

        // Default K=7 frame with random valid gaps against the reference model
        qc.delete();
        hist.delete();
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        chk("c_data_rdy", {c_busy, c_rdy}, 2'b11);
        n = 0; guard = 0; rdy_bad = 0;
        while (n < 1024 && guard < 10000) begin
            c_vld = 1'($urandom_range(0, 1));
            c_bit = 1'($urandom_range(0, 1));
            if (c_vld) begin
                if (c_rdy !== 1'b1) rdy_bad++;
                hist.push_back(c_bit);
                n++;
            end
            tick();
            guard++;
        end
        c_vld = 1'b0;
        chk("c_bits_sent", n, 1024);
        chk("c_tail_rdy", {c_busy, c_rdy}, 2'b10);
        repeat (6) hist.push_back(1'b0);
        w = 0;
        while (c_busy && w < 50) begin
            tick();
            w++;
        end
        chk("c_idle_bound", c_busy, 0);
        tick();
        tick();
        chk("c_rdy_handshake", rdy_bad, 0);
        chk("c_count", qc.size(), 1030);
        word_bad = 0; first_bad = -1;
        for (int i = 0; i < 1030; i++) begin
            obs = (i < qc.size()) ? qc[i] : 4'hF;
            exp = {(i == 1029), (i == 0), ref_word(i)};
            if (obs !== exp) begin
                word_bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        chk($sformatf("c_words_first_bad_%0d", first_bad), word_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
